// File: rtl/ode_ram_port_arbiter.sv
// ode_ram_port_arbiter: round-robin owner of the shared single-port solver RAM, with burst lock.
// Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD locked beats when others are waiting.
module ode_ram_port_arbiter #(
    parameter int NREQ     = 4,
    parameter int AW       = 11,
    parameter int DW       = 64,
    parameter int MAX_HOLD = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [IW-1:0] owner, owner_n, rr_ptr, rr_ptr_n, winner, base, idx;
    logic [NREQ-1:0] owner_oh, cand, gnt_n, rvalid_n;
    logic any_cand, keep, release_g, force_rot;
    assign busy      = (state == GRANT);
    assign owner_oh  = NREQ'(1) << owner;
    assign mem_en    = busy & req[owner];
    assign mem_we    = mem_en & we[owner];
    assign mem_addr  = addr[owner*AW +: AW];
    assign mem_wdata = wdata[owner*DW +: DW];
    assign rdata     = mem_rdata;
    // While granted the current owner is excluded so a release always rotates past it.
    always_comb begin
        base     = busy ? owner : rr_ptr;
        cand     = req & ~(busy ? owner_oh : '0);
        any_cand = |cand;
        winner   = '0;
        idx      = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IW'((int'(base) + i) % NREQ);
            if (cand[idx]) winner = idx;
        end
    end
`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD);
    logic [HW-1:0] hold_cnt, hold_n;
    assign force_rot = busy & req[owner] & lock[owner] & any_cand & (hold_cnt == HW'(MAX_HOLD-1));
    // Saturates so a late-arriving competitor is served at once after a long lock.
    assign hold_n = keep ? ((hold_cnt == HW'(MAX_HOLD-1)) ? hold_cnt : hold_cnt + 1'b1) : '0;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            hold_cnt    <= hold_n;
            timeout_err <= force_rot;
        end
    end
`else
    assign force_rot   = 1'b0;
    assign timeout_err = 1'b0;
`endif
    always_comb begin
        keep      = busy & req[owner] & lock[owner] & ~force_rot;
        release_g = busy & ~keep;
        state_n   = (keep | any_cand) ? GRANT : IDLE;
        owner_n   = keep ? owner : (any_cand ? winner : owner);
        rr_ptr_n  = release_g ? owner : rr_ptr;
        gnt_n     = (state_n == GRANT) ? (NREQ'(1) << owner_n) : '0;
        rvalid_n  = (mem_en & ~mem_we) ? owner_oh : '0;
    end
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= IW'(NREQ-1);
            gnt    <= '0;
            rvalid <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            rr_ptr <= rr_ptr_n;
            gnt    <= gnt_n;
            rvalid <= rvalid_n;
        end
    end
endmodule
